sub16_serial: RTL and testbench



---
 rtl/sub16_serial.sv | 136 +++++++++++++
 tb/tb_sub16_serial.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub16_serial.sv
// Digit-serial subtractor: y = a - b - Bin, processed DIGIT bits per clock, LSB digit first.
// A valid/ready handshake is used on both sides. All outputs come straight from registers.
module sub16_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             Bo,
   output logic             ov,
   output logic             busy
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int MSB  = WIDTH - 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state, w_state_next;
   logic [WIDTH-1:0] r_a, w_a_next;
   logic [WIDTH-1:0] r_b, w_b_next;
   logic             r_borrow, w_borrow_next;
   logic [CW-1:0]    r_cnt, w_cnt_next;
   logic [WIDTH-1:0] r_y, w_y_next;
   logic             r_bo, w_bo_next;
   logic             r_ov, w_ov_next;
   logic             r_in_ready, w_in_ready_next;
   logic             r_out_valid, w_out_valid_next;
   logic             r_busy, w_busy_next;

   int               w_base;
   logic [DIGIT-1:0] w_a_dig, w_b_dig;
   logic [DIGIT:0]   w_diff;

   // One extra bit on the digit difference: it goes to 1 exactly when the digit underflows.
   always_comb begin
      w_base  = int'(r_cnt) * DIGIT;
      w_a_dig = r_a[w_base +: DIGIT];
      w_b_dig = r_b[w_base +: DIGIT];
      w_diff  = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {{DIGIT{1'b0}}, r_borrow};
   end

   always_comb begin
      w_state_next     = r_state;
      w_a_next         = r_a;
      w_b_next         = r_b;
      w_borrow_next    = r_borrow;
      w_cnt_next       = r_cnt;
      w_y_next         = r_y;
      w_bo_next        = r_bo;
      w_ov_next        = r_ov;
      w_in_ready_next  = r_in_ready;
      w_out_valid_next = r_out_valid;
      w_busy_next      = r_busy;
      case (r_state)
         S_IDLE: begin
            if (in_valid && r_in_ready) begin
               w_a_next        = a;
               w_b_next        = b;
               w_borrow_next   = Bin;
               w_cnt_next      = '0;
               w_in_ready_next = 1'b0;
               w_busy_next     = 1'b1;
               w_state_next    = S_RUN;
            end
         end
         S_RUN: begin
            w_y_next[w_base +: DIGIT] = w_diff[DIGIT-1:0];
            w_borrow_next             = w_diff[DIGIT];
            w_cnt_next                = r_cnt + 1'b1;
            if (r_cnt == LAST) begin
               w_bo_next        = w_diff[DIGIT];
               // Signed overflow uses the fully assembled result, including the digit written this cycle.
               w_ov_next        = (r_a[MSB] != r_b[MSB]) && (w_y_next[MSB] != r_a[MSB]);
               w_out_valid_next = 1'b1;
               w_state_next     = S_DONE;
            end
         end
         S_DONE: begin
            if (r_out_valid && out_ready) begin
               w_out_valid_next = 1'b0;
               w_busy_next      = 1'b0;
               w_in_ready_next  = 1'b1;
               w_state_next     = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_borrow    <= 1'b0;
         r_cnt       <= '0;
         r_y         <= '0;
         r_bo        <= 1'b0;
         r_ov        <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_a         <= w_a_next;
         r_b         <= w_b_next;
         r_borrow    <= w_borrow_next;
         r_cnt       <= w_cnt_next;
         r_y         <= w_y_next;
         r_bo        <= w_bo_next;
         r_ov        <= w_ov_next;
         r_in_ready  <= w_in_ready_next;
         r_out_valid <= w_out_valid_next;
         r_busy      <= w_busy_next;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign y         = r_y;
   assign Bo        = r_bo;
   assign ov        = r_ov;
   assign busy      = r_busy;

endmodule

// File: tb/tb_sub16_serial.sv
// Self-checking bench for sub16_serial: scoreboard of expected results, one task per scenario.
module tb_sub16_serial;

   localparam int NDIG = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        Bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] y;
   logic        Bo;
   logic        ov;
   logic        busy;

   typedef struct packed {
      logic [15:0] y;
      logic        bo;
      logic        ov;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   sub16_serial #(.WIDTH(16), .DIGIT(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .Bin      (Bin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .y        (y),
      .Bo       (Bo),
      .ov       (ov),
      .busy     (busy)
   );

   function automatic exp_t model(input logic [15:0] fa, input logic [15:0] fb, input logic fbin);
      logic [16:0] d;
      exp_t        e;
      d    = {1'b0, fa} - {1'b0, fb} - {16'd0, fbin};
      e.y  = d[15:0];
      e.bo = d[16];
      e.ov = (fa[15] != fb[15]) && (d[15] != fa[15]);
      return e;
   endfunction

   // One complete transaction: accept, measure latency, compare, optional backpressure, release.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                         input int bp, input string name);
      exp_t e;
      int   lat;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s in_ready_idle actual=%0b required=1", name, in_ready);
      end
      a = ta; b = tb_v; Bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
      sb_q.push_back(model(ta, tb_v, tbin));
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); Bin = 1'($urandom_range(0, 1));
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         total++;
         if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s run_flags cyc=%0d in_ready=%0b busy=%0b required in_ready=0 busy=1",
                     name, lat, in_ready, busy);
         end
      end while (out_valid !== 1'b1 && lat < 20);
      total++;
      if (lat != NDIG) begin
         bad++;
         $display("FAIL %s latency actual=%0d required=%0d", name, lat, NDIG);
      end
      if (out_valid !== 1'b1) begin
         void'(sb_q.pop_front());
         return;
      end
      if (sb_q.size() == 0) begin
         total++; bad++;
         $display("FAIL %s scoreboard_empty actual=0 required>=1", name);
         return;
      end
      e = sb_q.pop_front();
      total++;
      if (y !== e.y) begin
         bad++;
         $display("FAIL %s y actual=%h required=%h", name, y, e.y);
      end
      total++;
      if (Bo !== e.bo) begin
         bad++;
         $display("FAIL %s Bo actual=%0b required=%0b", name, Bo, e.bo);
      end
      total++;
      if (ov !== e.ov) begin
         bad++;
         $display("FAIL %s ov actual=%0b required=%0b", name, ov, e.ov);
      end
      for (int i = 0; i < bp; i++) begin
         in_valid = 1'b1;
         a = 16'($urandom); b = 16'($urandom); Bin = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || y !== e.y || Bo !== e.bo || ov !== e.ov || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s hold cyc=%0d out_valid=%0b y=%h Bo=%0b ov=%0b in_ready=%0b required 1 %h %0b %0b 0",
                     name, i, out_valid, y, Bo, ov, in_ready, e.y, e.bo, e.ov);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s release out_valid=%0b in_ready=%0b busy=%0b required 0 1 0",
                  name, out_valid, in_ready, busy);
      end
      $display("op %s a=%h b=%h Bin=%0b -> y=%h Bo=%0b ov=%0b lat=%0d", name, ta, tb_v, tbin, e.y, e.bo, e.ov, lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      a = 16'hAAAA; b = 16'h5555; Bin = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset flags in_ready=%0b out_valid=%0b busy=%0b required 1 0 0", in_ready, out_valid, busy);
      end
      total++;
      if (y !== 16'h0000 || Bo !== 1'b0 || ov !== 1'b0) begin
         bad++;
         $display("FAIL reset result y=%h Bo=%0b ov=%0b required 0000 0 0", y, Bo, ov);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      run_op(16'h1234, 16'h0234, 1'b0, 0, "basic");
   endtask

   task automatic test_underflow();
      run_op(16'h0000, 16'h0001, 1'b0, 0, "underflow");
   endtask

   task automatic test_overflow();
      run_op(16'h8000, 16'h0001, 1'b0, 0, "ovf_neg");
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, "ovf_pos");
   endtask

   task automatic test_borrow_chain();
      run_op(16'h0005, 16'h0005, 1'b1, 0, "borrow_bin");
      run_op(16'h1000, 16'h0001, 1'b0, 0, "borrow_ripple");
   endtask

   task automatic test_backpressure();
      run_op(16'h4321, 16'h1234, 1'b1, 3, "backpressure");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), i % 3, "b2b");
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      a = 16'h1234; b = 16'h0000; Bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL abort pre_state busy=%0b out_valid=%0b required 1 0", busy, out_valid);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (y !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || Bo !== 1'b0 || ov !== 1'b0) begin
         bad++;
         $display("FAIL abort immediate y=%h out_valid=%0b in_ready=%0b busy=%0b Bo=%0b ov=%0b required 0000 0 1 0 0 0",
                  y, out_valid, in_ready, busy, Bo, ov);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(16'hFFFF, 16'h0001, 1'b0, 0, "post_abort");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_overflow();
      test_borrow_chain();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
